fifo_write_arbiter: RTL and testbench
=====================================

# fifo_write_arbiter

Round-robin write-port arbiter that shares a single `fifo` instance between `NUM_REQ` producers, such as systolic-array row/column feeders or result collectors. Each producer presents a valid/ready stream. The arbiter grants one producer at a time for a burst of up to `BURST_LEN` beats and drives the fifo's `w_en`/`in_data` directly from the granted stream, stalling on `full`. It sits between the producers and the fifo write port; the fifo's read side is untouched.

## Interface
- `NUM_REQ`, default 4: number of requesters, ≥2.
- `DATA_WIDTH`, default 16: beat width; must match the fifo's `DATA_WIDTH`.
- `BURST_LEN`, default 4: maximum consecutive beats per grant, ≥1.
- `clk` input, 1: single clock, rising edge.
- `rstn` input, 1: asynchronous active-low reset.
- `req_valid` input, NUM_REQ: bit i set means requester i has a beat.
- `req_data` input, NUM_REQ*DATA_WIDTH: requester i's data in bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready` output, NUM_REQ: bit i means requester i's beat is accepted this cycle.
- `fifo_full` input, 1: connect to the fifo's `full`.
- `fifo_w_en` output, 1: connect to the fifo's `w_en`.
- `fifo_in_data` output, DATA_WIDTH: connect to the fifo's `in_data`.
- `grant_valid` output, 1: arbiter is in the GRANT state.
- `grant_id` output, $clog2(NUM_REQ): index of the current or most recent grantee.

## Operation
- FSM states are IDLE and GRANT. Registers:
  - `state`
  - `grant_id`
  - `rr_ptr` ($clog2(NUM_REQ) bits; highest-priority index for the next arbitration)
  - `beat_cnt` ($clog2(BURST_LEN+1) bits)
- Arbitration (combinational): scan `req_valid` starting at `rr_ptr`, ascending with wrap modulo NUM_REQ; the first set bit wins.
- IDLE:
  - If any `req_valid` is set, go to GRANT next edge with `grant_id` = winner, `rr_ptr` = (winner+1) mod NUM_REQ, `beat_cnt` = 0.
  - Otherwise stay in IDLE.
- GRANT:
  - Transfer condition: `xfer` = `req_valid[grant_id]` & ~`fifo_full`.
  - `fifo_w_en` = `xfer`.
  - `req_ready[grant_id]` = `xfer`. All other `req_ready` bits are 0.
  - `fifo_in_data` = `req_data` slice of `grant_id` (driven whenever in GRANT). In IDLE it is 0.
  - On `xfer`, `beat_cnt` increments.
- Release condition in GRANT: (`xfer` & `beat_cnt` == BURST_LEN-1) | ~`req_valid[grant_id]`.
  - On release, re-arbitrate in the same cycle using the current `rr_ptr`. The current grantee is naturally lowest priority.
  - If there is a winner, stay in GRANT with the new `grant_id`, update `rr_ptr`, and clear `beat_cnt`. This may re-grant the same requester if it is the only one valid.
  - If there is no winner, go to IDLE.
- `fifo_full` in GRANT: hold the grant, no transfer, `beat_cnt` unchanged. There is no timeout and no release while the grantee stays valid.
- Requester contract: once `req_valid` is high, data is held stable until `req_ready`. Dropping valid early is legal; the beat is simply not taken.
- Only one `fifo_w_en` pulse per cycle. The arbiter never writes while `fifo_full` = 1, which keeps the fifo's full guard redundant but safe. The fifo stores at most DEPTH-1 entries; no extra accounting is needed here.
- Reset (asynchronous, any state, including mid-burst):
  - `state` = IDLE, `grant_id` = 0, `rr_ptr` = 0, `beat_cnt` = 0.
  - All outputs deassert immediately: `req_ready` = 0, `fifo_w_en` = 0, `fifo_in_data` = 0, `grant_valid` = 0.
  - A partial burst is abandoned; beats already written remain in the fifo.

## Timing
- Request in IDLE at cycle 0: `grant_valid` = 1 from cycle 1, and the first beat is accepted in cycle 1 if the fifo is not full. Idle-to-first-write latency is 1 cycle.
- Back-to-back grants incur 0 bubble cycles when release is caused by burst end.
- Release because the grantee dropped valid costs 1 non-transfer cycle.
- `req_ready`, `fifo_w_en` and `fifo_in_data` are combinational from registered state plus `req_valid`, `fifo_full` and `req_data`. There is no combinational path from `req_ready` back to `req_valid`.
- The fifo latches the beat on the same edge the arbiter counts it.
- Fairness: with all requesters continuously valid and the fifo never full, the grant sequence is 0,1,2,…,NUM_REQ-1,0,… with BURST_LEN beats each.

## Test plan
- **Single requester:** reset, then `req_valid` = 4'b0100 held, fifo drained each cycle. Expect `grant_id` = 2 from cycle 1, `fifo_w_en` every cycle, and release plus re-grant to 2 after every 4 beats with no gap.
- **Full contention:** all 4 valid, distinct data per requester (0x1000+i·0x100+beat). Expect the fifo write order to be 4 beats of req0, then req1, req2, req3, wrapping to req0.
- **Backpressure:** `fifo_full` forced to 1 for cycles 3–6 mid-burst. Expect `fifo_w_en` = 0 and `req_ready` = 0 in those cycles, `beat_cnt` frozen, and the burst to resume at beat 2 after full drops.
- **Early drop:** req1 granted, drops valid after 2 beats while req3 is valid. Expect 1 idle-transfer cycle, then `grant_id` = 3 with `rr_ptr` = 0.
- **Mid-burst reset:** assert `rstn` = 0 asynchronously during beat 2 of req0. Expect all outputs 0 immediately. After release, with req0 and req1 valid, req0 wins first (`rr_ptr` reset to 0).
- **Wrap-around:** `NUM_REQ` = 3, `BURST_LEN` = 1, requests only from 2 and 0. Expect alternating grants 0,2,0,2, with `rr_ptr` wrapping 0→1→0.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//   Round-robin arbiter that shares one fifo write port between NUM_REQ
//   valid/ready producers. A grantee holds the port for up to BURST_LEN
//   accepted beats, or until it drops valid. Each grant ends with a
//   re-arbitration in the same cycle. The rotating pointer starts just past
//   the last winner, so the outgoing grantee has the lowest priority.
//
// Ports
//   clk, rstn      clock (rising edge) / asynchronous active-low reset
//   req_valid      per-requester beat available
//   req_data       packed requester data, slot i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready      per-requester beat accepted this cycle
//   fifo_full      fifo full flag; no write is issued while set
//   fifo_w_en      fifo write strobe
//   fifo_in_data   fifo write data (0 while idle)
//   grant_valid    arbiter holds a grant
//   grant_id       current or most recent grantee
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no grant; waiting for any req_valid
// GRANT | grant_id owns the fifo write port; beat_cnt counts its beats

module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = 4,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW  = $clog2(BURST_LEN + 1)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_in_data,
  output logic                          grant_valid,
  output logic [IDW-1:0]                grant_id
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [CW-1:0]  beat_cnt;

  logic           arb_found;
  logic [IDW-1:0] arb_idx;
  logic [IDW-1:0] arb_next_ptr;
  logic           in_grant;
  logic           xfer;
  logic           burst_end;
  logic           release_c;

  // Scan from the highest offset down to zero so that the last match,
  // which is the one closest to rr_ptr, is the one that sticks.
  always_comb begin
    int idx;
    arb_found = 1'b0;
    arb_idx   = '0;
    idx       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (req_valid[idx]) begin
        arb_found = 1'b1;
        arb_idx   = IDW'(idx);
      end
    end
  end

  assign arb_next_ptr = (arb_idx == IDW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;

  assign in_grant  = (state == GRANT);
  assign xfer      = in_grant & req_valid[grant_id] & ~fifo_full;
  assign burst_end = xfer & (beat_cnt == CW'(BURST_LEN - 1));
  assign release_c = in_grant & (burst_end | ~req_valid[grant_id]);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_found) begin
            state    <= GRANT;
            grant_id <= arb_idx;
            rr_ptr   <= arb_next_ptr;
            beat_cnt <= '0;
          end
        end
        GRANT: begin
          if (release_c) begin
            if (arb_found) begin
              grant_id <= arb_idx;
              rr_ptr   <= arb_next_ptr;
              beat_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end else if (xfer) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[grant_id] = 1'b1;
  end

  assign fifo_w_en    = xfer;
  assign fifo_in_data = in_grant ? req_data[grant_id*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign grant_valid  = in_grant;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int B  = 4;
  localparam int DW = 16;

  logic              clk;
  logic              rstn;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              fifo_full;
  logic              fifo_w_en;
  logic [DW-1:0]     fifo_in_data;
  logic              grant_valid;
  logic [1:0]        grant_id;
  logic [DW-1:0]     dat [N];

  // second instance: 3 requesters, single-beat bursts
  logic [2:0]        w_valid;
  logic [23:0]       w_data;
  logic [2:0]        w_ready;
  logic              w_full;
  logic              w_w_en;
  logic [7:0]        w_in;
  logic              w_gv;
  logic [1:0]        w_gid;

  int n_chk = 0;
  int n_err = 0;

  // behavioural model state
  bit     m_busy;
  int     m_gid;
  int     m_ptr;
  int     m_beats;
  logic [N-1:0] last_acc;

  bit chk_order = 0;
  int n_wr = 0;
  bit wrap_on = 0;
  int wk = 0;

  fifo_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_LEN(B)) u_dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_w_en(fifo_w_en),
    .fifo_in_data(fifo_in_data), .grant_valid(grant_valid), .grant_id(grant_id)
  );

  fifo_write_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8), .BURST_LEN(1)) u_wrap (
    .clk(clk), .rstn(rstn), .req_valid(w_valid), .req_data(w_data),
    .req_ready(w_ready), .fifo_full(w_full), .fifo_w_en(w_w_en),
    .fifo_in_data(w_in), .grant_valid(w_gv), .grant_id(w_gid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = dat[i];
  end

  assign w_data = 24'h33_22_11;
  assign w_full = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++)
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_gid = 0; m_ptr = 0; m_beats = 0; last_acc = '0;
  endtask

  // Called at a falling edge with inputs already driven: checks this cycle's
  // outputs against the model, advances the model, waits for the next fall.
  task automatic cycle();
    logic          exp_w;
    logic [N-1:0]  exp_rdy;
    logic [DW-1:0] exp_d;
    logic [DW-1:0] exp_o;
    int            w;
    #1;
    exp_w = 1'b0; exp_rdy = '0; exp_d = '0;
    if (m_busy) begin
      exp_w = req_valid[m_gid] && !fifo_full;
      exp_d = dat[m_gid];
      if (exp_w) exp_rdy[m_gid] = 1'b1;
    end
    chk("w_en",   {31'b0, fifo_w_en},   {31'b0, exp_w});
    chk("ready",  {28'b0, req_ready},   {28'b0, exp_rdy});
    chk("data",   {16'b0, fifo_in_data}, {16'b0, exp_d});
    chk("gvalid", {31'b0, grant_valid}, {31'b0, m_busy});
    chk("gid",    {30'b0, grant_id},    m_gid);
    if (chk_order && fifo_w_en) begin
      exp_o = 16'h1000 + DW'(((n_wr / 4) % 4) * 16'h100) + DW'((n_wr / 16) * 4 + n_wr % 4);
      chk("order", {16'b0, fifo_in_data}, {16'b0, exp_o});
      n_wr++;
    end
    if (wrap_on) begin
      if (wk == 0) chk("wrap_gv", {31'b0, w_gv}, 0);
      else begin
        chk("wrap_gid",  {30'b0, w_gid}, (wk % 2 == 1) ? 0 : 2);
        chk("wrap_w_en", {31'b0, w_w_en}, 1);
      end
      wk++;
    end
    last_acc = exp_rdy;
    if (!m_busy) begin
      w = pick();
      if (w >= 0) begin m_busy = 1; m_gid = w; m_ptr = (w + 1) % N; m_beats = 0; end
    end else begin
      if (exp_w) m_beats++;
      if ((exp_w && m_beats == B) || !req_valid[m_gid]) begin
        w = pick();
        if (w >= 0) begin m_gid = w; m_ptr = (w + 1) % N; m_beats = 0; end
        else m_busy = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    req_valid = '0; fifo_full = 1'b0; w_valid = '0;
    rstn = 1'b0;
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  int cnt [N];

  initial begin
    rstn = 1'b0; req_valid = '0; fifo_full = 1'b0; w_valid = '0;
    for (int i = 0; i < N; i++) dat[i] = '0;
    model_reset();
    @(negedge clk);
    chk("rst_w_en",  {31'b0, fifo_w_en}, 0);
    chk("rst_ready", {28'b0, req_ready}, 0);
    chk("rst_gv",    {31'b0, grant_valid}, 0);
    chk("rst_gid",   {30'b0, grant_id}, 0);

    // single requester, plus the 3-requester wrap instance alongside
    do_reset();
    req_valid = 4'b0100; w_valid = 3'b101; wrap_on = 1; wk = 0;
    for (int c = 0; c < 14; c++) begin
      cycle();
      if (last_acc[2]) dat[2] = DW'($urandom);
    end
    wrap_on = 0;

    // full contention, write order check
    do_reset();
    for (int i = 0; i < N; i++) cnt[i] = 0;
    chk_order = 1; n_wr = 0;
    req_valid = 4'b1111;
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < N; i++) dat[i] = 16'h1000 + DW'(i * 16'h100) + DW'(cnt[i]);
      cycle();
      for (int i = 0; i < N; i++) if (last_acc[i]) cnt[i]++;
    end
    chk_order = 0;
    chk("order_count", n_wr, 39);

    // backpressure mid-burst
    do_reset();
    req_valid = 4'b0001; dat[0] = 16'h0a00;
    for (int c = 0; c < 12; c++) begin
      fifo_full = (c >= 3 && c <= 6);
      cycle();
      if (last_acc[0]) dat[0] = dat[0] + 1'b1;
    end
    fifo_full = 1'b0;

    // early drop of req1 while req3 waits
    do_reset();
    req_valid = 4'b1010;
    cycle(); cycle(); cycle();
    req_valid[1] = 1'b0;
    cycle();
    #1 chk("drop_gid", {30'b0, grant_id}, 3);
    chk("drop_gv", {31'b0, grant_valid}, 1);
    @(negedge clk);
    cycle(); cycle();

    // asynchronous reset during beat 2 of req0
    do_reset();
    req_valid = 4'b0011;
    cycle(); cycle(); cycle();
    #1 rstn = 1'b0;
    #1;
    chk("mrst_w_en",  {31'b0, fifo_w_en}, 0);
    chk("mrst_ready", {28'b0, req_ready}, 0);
    chk("mrst_data",  {16'b0, fifo_in_data}, 0);
    chk("mrst_gv",    {31'b0, grant_valid}, 0);
    chk("mrst_gid",   {30'b0, grant_id}, 0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 6; c++) cycle();

    // randomized traffic honouring the hold-until-ready contract
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && !last_acc[i]) begin
          if ($urandom_range(15) == 0) req_valid[i] = 1'b0;
        end else begin
          req_valid[i] = ($urandom_range(2) != 0);
          dat[i] = DW'($urandom);
        end
      end
      fifo_full = ($urandom_range(3) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
